bin2bcd_disp: RTL and testbench
===============================

BIN2BCD_DISP -- requirements
Module: bin2bcd_disp

Interface
REQ-001 Parameter W, default 14, SHALL set the binary input width; the legal range is 14 to 16.
REQ-002 Parameter MAX_DISP, default 9999, SHALL be the largest value that four digits can show.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL be a one-cycle request to convert bin; it is sampled only while ready=1.
REQ-006 bin  input  W  SHALL be the unsigned binary value, sampled on the cycle start is accepted.
REQ-007 ready  output  1  SHALL be high only in IDLE, meaning a new start will be accepted.
REQ-008 done_tick  output  1  SHALL pulse for one cycle when new digits appear on hex3..hex0.
REQ-009 hex3, hex2, hex1, hex0  output  4 each  SHALL be the registered BCD thousands, hundreds, tens and units digits; they feed the 7-seg mux hex inputs.
REQ-010 dp_out  output  4  SHALL be the registered decimal-point pattern, active-low; it feeds the 7-seg mux dp_in.

Function
REQ-011 The FSM SHALL have three states: IDLE, OP and DONE.
REQ-012 IDLE + start: latch bin into shift register s; clear the internal 16-bit BCD accumulator; load n=W; go to OP.
REQ-013 Each OP cycle SHALL, in order: add 3 to every accumulator digit greater than 4; shift {bcd,s} left by one; decrement n.
REQ-014 OP with n==1 SHALL go to DONE on that edge and load hex3..hex0 with the post-shift accumulator.
REQ-015 DONE SHALL assert done_tick=1 for exactly one cycle, then go to IDLE.
REQ-016 Latency: start sampled at edge 0 gives done_tick high and new digits valid in cycle W+1 (cycle 15 at W=14); ready is high again from cycle W+2.
REQ-017 hex3..hex0 and dp_out SHALL hold their last values at all times except at the DONE-entry edge (glitch-free for the display).
REQ-018 start while ready=0 SHALL be ignored and not queued; bin changes during OP SHALL have no effect.
REQ-019 Each digit adder SHALL be 4 bits wide; any carry out of the thousands digit SHALL be discarded, so the result is bin mod 10000.
REQ-020 start asserted in the DONE cycle SHALL be ignored; start in the first IDLE cycle SHALL be accepted.

Reset
REQ-021 While reset=1 at an edge: state becomes IDLE, hex3..hex0 become 0, dp_out becomes 4'b1111, done_tick becomes 0, and s, bcd and n become 0.
REQ-022 Reset during OP or DONE SHALL abort the conversion with no done_tick; ready=1 from the first post-reset cycle.
REQ-023 reset SHALL take priority over start in the same cycle.

Configuration
REQ-024 With macro BIN2BCD_SAT_EN defined, a latched bin > MAX_DISP SHALL produce digits 9,9,9,9 and dp_out=4'b0000 (all points lit as an overflow flag), with unchanged latency.
REQ-025 With BIN2BCD_SAT_EN defined and bin <= MAX_DISP, dp_out SHALL be 4'b1111.
REQ-026 With BIN2BCD_SAT_EN undefined, no comparator SHALL be built, the mod-10000 result of REQ-019 SHALL be shown, and dp_out SHALL always be 4'b1111.

Structure
REQ-027 A shared package disp_pkg SHALL hold the FSM state encoding (IDLE=2'b00, OP=2'b01, DONE=2'b10), BCD_DIGITS=4, MAX_DISP=9999, and the constant DP_OFF=4'b1111.
REQ-028 A single sub-module, bcd_adj3, SHALL implement the 4-bit "add 3 if greater than 4" correction and be instantiated 4 times.
REQ-029 The implementation SHALL contain no combinational path from start or bin to any output.

Verification
REQ-030 bin=0, start -> cycle 15: done_tick=1, hex3..hex0=0,0,0,0, dp_out=1111.
REQ-031 bin=1234 -> digits 1,2,3,4 in cycle W+1=15; ready low in cycles 1 to 15, high in cycle 16.
REQ-032 bin=9999 -> 9,9,9,9; then bin=12345 -> with BIN2BCD_SAT_EN: 9,9,9,9 and dp_out=0000; without: 2,3,4,5 and dp_out=1111.
REQ-033 start=1 at cycles 0, 5 and 15 with bins 42, 77 and 88 -> exactly one done_tick, digits 0,0,4,2; cycle-16 start with 88 -> 0,0,8,8.
REQ-034 Convert 1234, then start 5678 and assert reset at cycle 7 -> no done_tick, digits 0,0,0,0 after reset, ready=1 next cycle.
REQ-035 Digit stability: across a 4321 conversion, hex0 SHALL change only at the DONE-entry edge.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD display converter.
package disp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OP   = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int         BCD_DIGITS = 4;
   localparam int         MAX_DISP   = 9999;
   localparam logic [3:0] DP_OFF     = 4'b1111;
   localparam logic [3:0] DP_SAT     = 4'b0000;

endpackage

// File: rtl/bcd_adj3.sv
// One BCD digit correction step of double-dabble: add 3 when the digit exceeds 4.
module bcd_adj3 (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   assign digit_o = (digit_i > 4'd4) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_disp.sv
// Iterative double-dabble converter feeding a 4-digit 7-segment mux (one bit per cycle).
// Optional BIN2BCD_SAT_EN: inputs above MAX_DISP show 9999 with every decimal point lit.
module bin2bcd_disp #(
   parameter int W        = 14,
   parameter int MAX_DISP = 9999
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] bin,
   output logic         ready,
   output logic         done_tick,
   output logic [3:0]   hex3,
   output logic [3:0]   hex2,
   output logic [3:0]   hex1,
   output logic [3:0]   hex0,
   output logic [3:0]   dp_out
);
   import disp_pkg::*;

   localparam int NW = $clog2(W + 1);
   localparam int DW = 4 * BCD_DIGITS;

   if (W < 14 || W > 16 || MAX_DISP > 9999) begin : g_bad_cfg
      $error("bin2bcd_disp: unsupported W or MAX_DISP");
   end

   state_t          state_q, state_d;
   logic [W-1:0]    s_q, s_d;
   logic [DW-1:0]   bcd_q, bcd_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DW-1:0]   hex_q, hex_d;
   logic [3:0]      dp_q, dp_d;
   logic [DW-1:0]   bcd_adj;
   logic [DW-1:0]   bcd_shift;
   logic            unused_carry;

`ifdef BIN2BCD_SAT_EN
   localparam logic [W-1:0] MAX_BIN = W'(MAX_DISP);
   logic sat_q, sat_d;
`endif

   for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
      bcd_adj3 u_adj (
         .digit_i (bcd_q[4*gi +: 4]),
         .digit_o (bcd_adj[4*gi +: 4])
      );
   end

   // The bit shifted out of the thousands digit is the discarded carry (mod 10000).
   assign {unused_carry, bcd_shift} = {bcd_adj, s_q[W-1]};

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      bcd_d   = bcd_q;
      n_d     = n_q;
      hex_d   = hex_q;
      dp_d    = dp_q;
`ifdef BIN2BCD_SAT_EN
      sat_d   = sat_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               s_d     = bin;
               bcd_d   = '0;
               n_d     = NW'(W);
               state_d = OP;
`ifdef BIN2BCD_SAT_EN
               sat_d   = (bin > MAX_BIN);
`endif
            end
         end
         OP: begin
            s_d   = {s_q[W-2:0], 1'b0};
            bcd_d = bcd_shift;
            n_d   = n_q - NW'(1);
            if (n_q == NW'(1)) begin
               state_d = DONE;
               hex_d   = bcd_shift;
               dp_d    = DP_OFF;
`ifdef BIN2BCD_SAT_EN
               if (sat_q) begin
                  hex_d = {BCD_DIGITS{4'd9}};
                  dp_d  = DP_SAT;
               end
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         bcd_q   <= '0;
         n_q     <= '0;
         hex_q   <= '0;
         dp_q    <= DP_OFF;
`ifdef BIN2BCD_SAT_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         bcd_q   <= bcd_d;
         n_q     <= n_d;
         hex_q   <= hex_d;
         dp_q    <= dp_d;
`ifdef BIN2BCD_SAT_EN
         sat_q   <= sat_d;
`endif
      end
   end

   // Outputs decode registered state only, so start/bin never reach them combinationally.
   assign ready     = (state_q == IDLE);
   assign done_tick = (state_q == DONE);
   assign hex3      = hex_q[15:12];
   assign hex2      = hex_q[11:8];
   assign hex1      = hex_q[7:4];
   assign hex0      = hex_q[3:0];
   assign dp_out    = dp_q;

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Self-checking bench for bin2bcd_disp: vector table, corner sequences and random values.
module tb_bin2bcd_disp;

   localparam int W = 14;
`ifdef BIN2BCD_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] bin;
   logic         ready;
   logic         done_tick;
   logic [3:0]   hex3, hex2, hex1, hex0;
   logic [3:0]   dp_out;
   logic [15:0]  hex_all;

   int total = 0;
   int bad   = 0;
   logic [15:0] last_d;
   logic [3:0]  last_dp;

   typedef struct {
      int          b;
      logic [15:0] digits;
      logic [3:0]  dp;
   } vec_t;
   vec_t tbl[8];

   bin2bcd_disp #(.W(W), .MAX_DISP(9999)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bin       (bin),
      .ready     (ready),
      .done_tick (done_tick),
      .hex3      (hex3),
      .hex2      (hex2),
      .hex1      (hex1),
      .hex0      (hex0),
      .dp_out    (dp_out)
   );

   assign hex_all = {hex3, hex2, hex1, hex0};

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: decimal digits of the value (saturated when enabled), by plain arithmetic.
   function automatic logic [15:0] model_d(input int v);
      int m;
      if (SAT && v > 9999) return 16'h9999;
      m = v % 10000;
      return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   function automatic logic [3:0] model_dp(input int v);
      return (SAT && v > 9999) ? 4'b0000 : 4'b1111;
   endfunction

   // Called mid-cycle with the DUT idle; that cycle is cycle 0 of the conversion.
   task automatic run_conv(input int b, input logic [15:0] exp_d, input logic [3:0] exp_dp,
                           input string nm);
      chk({nm, "_ready_c0"}, int'(ready), 1);
      start = 1'b1;
      bin   = W'(b);
      @(posedge clk);
      #1;
      start = 1'b0;
      bin   = W'($urandom);
      for (int k = 1; k <= W + 2; k++) begin
         @(negedge clk);
         chk({nm, "_ready"}, int'(ready), int'(k >= W + 2));
         chk({nm, "_done"}, int'(done_tick), int'(k == W + 1));
         if (k <= W) begin
            chk({nm, "_hold_hex"}, int'(hex_all), int'(last_d));
            chk({nm, "_hold_dp"}, int'(dp_out), int'(last_dp));
         end else if (k == W + 1) begin
            chk({nm, "_digits"}, int'(hex_all), int'(exp_d));
            chk({nm, "_dp"}, int'(dp_out), int'(exp_dp));
         end
      end
      last_d  = exp_d;
      last_dp = exp_dp;
      $display("conv %s bin=%0d digits=%h dp=%b", nm, b, hex_all, dp_out);
   endtask

   initial begin
      int dones;
      int b;

      tbl[0] = '{0,     16'h0000, 4'b1111};
      tbl[1] = '{1234,  16'h1234, 4'b1111};
      tbl[2] = '{9999,  16'h9999, 4'b1111};
      tbl[3] = '{12345, SAT ? 16'h9999 : 16'h2345, SAT ? 4'b0000 : 4'b1111};
      tbl[4] = '{4321,  16'h4321, 4'b1111};
      tbl[5] = '{10000, SAT ? 16'h9999 : 16'h0000, SAT ? 4'b0000 : 4'b1111};
      tbl[6] = '{5,     16'h0005, 4'b1111};
      tbl[7] = '{16383, SAT ? 16'h9999 : 16'h6383, SAT ? 4'b0000 : 4'b1111};

      reset = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", int'(ready), 1);
      chk("rst_done", int'(done_tick), 0);
      chk("rst_hex", int'(hex_all), 0);
      chk("rst_dp", int'(dp_out), 4'hF);
      $display("reset ready=%b digits=%h dp=%b", ready, hex_all, dp_out);
      last_d  = 16'h0000;
      last_dp = 4'b1111;

      for (int i = 0; i < 8; i++) begin
         run_conv(tbl[i].b, tbl[i].digits, tbl[i].dp, $sformatf("vec%0d", i));
      end

      // Starts during OP and during DONE are dropped, not queued.
      dones = 0;
      start = 1'b1;
      bin   = W'(42);
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= W + 2; k++) begin
         @(negedge clk);
         dones += int'(done_tick);
         if (k == W + 1) chk("busy_digits", int'(hex_all), 16'h0042);
         start = (k == 5 || k == W + 1);
         bin   = (k == 5) ? W'(77) : W'(88);
      end
      start = 1'b0;
      chk("busy_one_done", dones, 1);
      $display("busy-start seq dones=%0d digits=%h", dones, hex_all);
      last_d  = 16'h0042;
      last_dp = 4'b1111;
      run_conv(88, 16'h0088, 4'b1111, "first_idle");

      // Reset mid-conversion aborts without a done_tick.
      run_conv(1234, 16'h1234, 4'b1111, "pre_abort");
      dones = 0;
      start = 1'b1;
      bin   = W'(5678);
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         dones += int'(done_tick);
      end
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_ready", int'(ready), 1);
      chk("abort_hex", int'(hex_all), 0);
      chk("abort_dp", int'(dp_out), 4'hF);
      for (int k = 0; k < W + 4; k++) begin
         @(negedge clk);
         dones += int'(done_tick);
      end
      chk("abort_no_done", dones, 0);
      $display("abort seq dones=%0d digits=%h", dones, hex_all);
      last_d  = 16'h0000;
      last_dp = 4'b1111;

      // Reset wins over a simultaneous start.
      dones = 0;
      reset = 1'b1;
      start = 1'b1;
      bin   = W'(99);
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("prio_ready", int'(ready), 1);
      for (int k = 0; k < W + 3; k++) begin
         @(negedge clk);
         dones += int'(done_tick);
      end
      chk("prio_no_done", dones, 0);
      chk("prio_hex", int'(hex_all), 0);
      $display("priority seq dones=%0d digits=%h", dones, hex_all);

      for (int i = 0; i < 20; i++) begin
         b = int'($urandom_range(0, (1 << W) - 1));
         run_conv(b, model_d(b), model_dp(b), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
